// File: rtl/deq_pkg.sv
// Shared widths, types and the reconstruction arithmetic for the dequantize/unbias stage.
// Build option: define DEQ_ROUND_EN to reconstruct the bin midpoint instead of the floor.
package deq_pkg;

    localparam int DIN_W  = 8;
    localparam int DOUT_W = 18;
    localparam int BIAS_W = 8;
    localparam int SHIFT  = 10;
    localparam int N_CH   = 4;
    localparam int CH_W   = $clog2(N_CH);
    localparam int CALC_W = DOUT_W + 1;

`ifdef DEQ_ROUND_EN
    localparam int ROUND_OFS = 1 << (SHIFT - 1);
`else
    localparam int ROUND_OFS = 0;
`endif

    typedef logic [DIN_W-1:0]         q_t;
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic [CH_W-1:0]          ch_t;
    typedef logic [DOUT_W-1:0]        dout_t;

    // One extra bit of headroom keeps the subtraction signed; the largest positive result
    // (255<<10 + 128 + 512) still fits in DOUT_W bits, so only the low side needs clamping.
    function automatic dout_t reconstruct(input q_t din, input bias_t bias);
        logic signed [CALC_W-1:0] scaled;
        logic signed [CALC_W-1:0] bias_ext;
        logic signed [CALC_W-1:0] acc;
        scaled   = $signed({1'b0, din, {SHIFT{1'b0}}});
        bias_ext = {{(CALC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        acc      = scaled - bias_ext + CALC_W'(ROUND_OFS);
        return acc[CALC_W-1] ? '0 : acc[DOUT_W-1:0];
    endfunction

endpackage

// File: rtl/dequantize_unbias_if.sv
// Stream-in, stream-out and bias-write signals of the dequantize/unbias stage.
// master = upstream/downstream environment, slave = the dequantizer.
interface dequantize_unbias_if;
    import deq_pkg::*;

    logic  bias_we;
    ch_t   bias_addr;
    bias_t bias_wdata;

    logic  din_valid;
    logic  din_ready;
    q_t    din;
    logic  din_last;

    logic  dout_valid;
    logic  dout_ready;
    dout_t dout;
    ch_t   dout_ch;
    logic  dout_last;

    modport master (
        output bias_we, bias_addr, bias_wdata,
        output din_valid, din, din_last,
        input  din_ready,
        input  dout_valid, dout, dout_ch, dout_last,
        output dout_ready
    );

    modport slave (
        input  bias_we, bias_addr, bias_wdata,
        input  din_valid, din, din_last,
        output din_ready,
        output dout_valid, dout, dout_ch, dout_last,
        input  dout_ready
    );

endinterface

// File: rtl/deq_bias_regfile.sv
// Per-channel signed bias table: one synchronous write port, one combinational read port.
// Writes to addresses outside 0..N_CH-1 match no entry and are dropped.
module deq_bias_regfile
    import deq_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  ch_t   waddr,
    input  bias_t wdata,
    input  ch_t   raddr,
    output bias_t rdata
);

    bias_t regs [N_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (waddr == ch_t'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Read is taken before the write edge, so a same-cycle write is seen by the next accept only.
    assign rdata = regs[raddr];

endmodule

// File: rtl/dequantize_unbias.sv
// Rebuilds accumulator-domain values from 8-bit activations: max(0, (din<<SHIFT) - bias[ch]).
// Two-stage valid/ready pipeline; DEQ_ROUND_EN (in deq_pkg) adds the half-bin offset.
module dequantize_unbias
    import deq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    dequantize_unbias_if.slave  bus
);

    logic  s1_valid;
    logic  s2_valid;
    logic  s1_adv;
    logic  s2_adv;
    logic  accept;

    ch_t   ch_cnt;
    bias_t rd_bias;

    q_t    s1_din;
    ch_t   s1_ch;
    logic  s1_last;
    bias_t s1_bias;

    dout_t s2_dout;
    ch_t   s2_ch;
    logic  s2_last;

    // Each stage may take a new word when it is empty or its occupant moves on.
    assign s2_adv = ~s2_valid | bus.dout_ready;
    assign s1_adv = ~s1_valid | s2_adv;
    assign accept = bus.din_valid & s1_adv;

    assign bus.din_ready  = s1_adv;
    assign bus.dout_valid = s2_valid;
    assign bus.dout       = s2_dout;
    assign bus.dout_ch    = s2_ch;
    assign bus.dout_last  = s2_last;

    deq_bias_regfile u_bias (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.bias_we),
        .waddr (bus.bias_addr),
        .wdata (bus.bias_wdata),
        .raddr (ch_cnt),
        .rdata (rd_bias)
    );

    // A frame boundary restarts channel numbering for the following word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
        end else if (accept) begin
            if (bus.din_last || ch_cnt == ch_t'(N_CH - 1)) begin
                ch_cnt <= '0;
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_ch    <= '0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_din  <= bus.din;
                s1_ch   <= ch_cnt;
                s1_last <= bus.din_last;
                s1_bias <= rd_bias;
            end
        end
    end

    // Output registers only move when downstream can take the word, which keeps them stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_dout  <= '0;
            s2_ch    <= '0;
            s2_last  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_dout <= reconstruct(s1_din, s1_bias);
                s2_ch   <= s1_ch;
                s2_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_dequantize_unbias.sv
// Randomized self-checking bench for dequantize_unbias against a plain-arithmetic model.
// Works in both builds; DEQ_ROUND_EN changes the model's half-bin offset.
module tb_dequantize_unbias;
    import deq_pkg::*;

`ifdef DEQ_ROUND_EN
    localparam int ROUND = 512;
`else
    localparam int ROUND = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    int stim_din[$];
    bit stim_last[$];
    bit stim_we[$];
    int stim_waddr[$];
    int stim_wdata[$];
    bit rdy_pat [512];

    int obs_dout[$];
    int obs_ch[$];
    bit obs_last[$];
    int acc_cyc[$];
    int out_cyc[$];
    int rdy_low_cyc[$];
    int hold_viol;

    int exp_dout[$];
    int exp_ch[$];
    bit exp_last[$];

    int mdl_bias [N_CH];
    int mdl_ch;

    dequantize_unbias_if bus ();

    dequantize_unbias dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int recon(input int d, input int b);
        int v;
        v = d * 1024 - b + ROUND;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) mdl_bias[i] = 0;
        mdl_ch = 0;
    endtask

    task automatic set_ready_all();
        for (int i = 0; i < 512; i++) rdy_pat[i] = 1'b1;
    endtask

    task automatic clear_stim();
        stim_din.delete();
        stim_last.delete();
        stim_we.delete();
        stim_waddr.delete();
        stim_wdata.delete();
    endtask

    task automatic add_word(input int d, input bit last, input bit we = 1'b0,
                            input int wa = 0, input int wd = 0);
        stim_din.push_back(d);
        stim_last.push_back(last);
        stim_we.push_back(we);
        stim_waddr.push_back(wa);
        stim_wdata.push_back(wd);
    endtask

    // Model: a bias write travelling with word i takes effect from word i+1 onward.
    task automatic build_expected();
        exp_dout.delete();
        exp_ch.delete();
        exp_last.delete();
        foreach (stim_din[i]) begin
            exp_dout.push_back(recon(stim_din[i], mdl_bias[mdl_ch]));
            exp_ch.push_back(mdl_ch);
            exp_last.push_back(stim_last[i]);
            mdl_ch = stim_last[i] ? 0 : (mdl_ch + 1) % N_CH;
            if (stim_we[i]) mdl_bias[stim_waddr[i]] = stim_wdata[i];
        end
    endtask

    task automatic write_bias(input int addr, input int val);
        @(negedge clk);
        bus.bias_we    = 1'b1;
        bus.bias_addr  = ch_t'(addr);
        bus.bias_wdata = bias_t'(val);
        @(negedge clk);
        bus.bias_we = 1'b0;
        mdl_bias[addr] = val;
    endtask

    // Drives the queued words and records what comes out; a bias write is raised only in a word's accept cycle.
    task automatic run_stream(input int budget);
        int idx;
        int cyc;
        bit prev_hold;
        int pd;
        int pc;
        bit pl;
        idx = 0; cyc = 0; prev_hold = 1'b0; pd = 0; pc = 0; pl = 1'b0;
        obs_dout.delete(); obs_ch.delete(); obs_last.delete();
        acc_cyc.delete(); out_cyc.delete(); rdy_low_cyc.delete();
        hold_viol = 0;
        @(negedge clk);
        while (obs_dout.size() < stim_din.size() && cyc < budget) begin
            if (idx < stim_din.size()) begin
                bus.din_valid = 1'b1;
                bus.din       = q_t'(stim_din[idx]);
                bus.din_last  = stim_last[idx];
            end else begin
                bus.din_valid = 1'b0;
                bus.din       = '0;
                bus.din_last  = 1'b0;
            end
            bus.dout_ready = rdy_pat[cyc % 512];
            bus.bias_we    = 1'b0;
            #1;
            if (bus.din_valid && bus.din_ready) begin
                bus.bias_we    = stim_we[idx];
                bus.bias_addr  = ch_t'(stim_waddr[idx]);
                bus.bias_wdata = bias_t'(stim_wdata[idx]);
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (!bus.din_ready) rdy_low_cyc.push_back(cyc);
            if (prev_hold && (!bus.dout_valid || int'(bus.dout) != pd ||
                              int'(bus.dout_ch) != pc || bus.dout_last != pl))
                hold_viol++;
            prev_hold = bus.dout_valid && !bus.dout_ready;
            pd = int'(bus.dout);
            pc = int'(bus.dout_ch);
            pl = bus.dout_last;
            if (bus.dout_valid && bus.dout_ready) begin
                obs_dout.push_back(int'(bus.dout));
                obs_ch.push_back(int'(bus.dout_ch));
                obs_last.push_back(bus.dout_last);
                out_cyc.push_back(cyc);
            end
            @(negedge clk);
            cyc++;
        end
        bus.din_valid  = 1'b0;
        bus.din_last   = 1'b0;
        bus.bias_we    = 1'b0;
        bus.dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || bus.dout !== '0 ||
            bus.dout_ch !== '0 || bus.dout_last !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_state: got valid=%b ready=%b dout=%0d ch=%0d last=%b, expected 0 1 0 0 0",
                     bus.dout_valid, bus.din_ready, bus.dout, bus.dout_ch, bus.dout_last);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        set_ready_all();
        clear_stim();
        add_word(3, 1'b1);
        build_expected();
        run_stream(40);
        n_vec++;
        if (obs_dout.size() != 1) begin
            n_err++;
            $display("[TB] FAIL basic_count: got %0d words, expected 1", obs_dout.size());
        end else begin
            n_vec++;
            if (obs_dout[0] !== 3072 + ROUND || obs_ch[0] !== 0 || obs_last[0] !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL basic_value: got dout=%0d ch=%0d last=%b, expected dout=%0d ch=0 last=1",
                         obs_dout[0], obs_ch[0], obs_last[0], 3072 + ROUND);
            end
            n_vec++;
            if (out_cyc[0] - acc_cyc[0] !== 2) begin
                n_err++;
                $display("[TB] FAIL basic_latency: got %0d cycles, expected 2", out_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_bias_clamp();
        write_bias(1, -2);
        write_bias(0, 5);
        write_bias(2, -128);
        clear_stim();
        add_word(0, 1'b0);
        add_word(3, 1'b0);
        add_word(255, 1'b1);
        add_word(0, 1'b1);
        build_expected();
        run_stream(60);
        n_vec++;
        if (obs_dout.size() != exp_dout.size()) begin
            n_err++;
            $display("[TB] FAIL bias_count: got %0d words, expected %0d", obs_dout.size(), exp_dout.size());
        end
        for (int i = 0; i < exp_dout.size() && i < obs_dout.size(); i++) begin
            n_vec++;
            if (obs_dout[i] !== exp_dout[i] || obs_ch[i] !== exp_ch[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("[TB] FAIL bias_word%0d: got dout=%0d ch=%0d last=%b, expected dout=%0d ch=%0d last=%b",
                         i, obs_dout[i], obs_ch[i], obs_last[i], exp_dout[i], exp_ch[i], exp_last[i]);
            end
        end
        if (obs_dout.size() == 4) begin
            n_vec++;
            if (obs_dout[1] !== 3074 + ROUND || obs_dout[2] !== 261248 + ROUND) begin
                n_err++;
                $display("[TB] FAIL bias_literals: got %0d %0d, expected %0d %0d",
                         obs_dout[1], obs_dout[2], 3074 + ROUND, 261248 + ROUND);
            end
        end
    endtask

    task automatic test_last_wrap();
        int ch_ref [6];
        ch_ref = '{0, 1, 2, 0, 1, 2};
        clear_stim();
        for (int i = 0; i < 6; i++) add_word(int'($urandom_range(255)), i == 2);
        build_expected();
        run_stream(60);
        n_vec++;
        if (obs_dout.size() != 6) begin
            n_err++;
            $display("[TB] FAIL last_count: got %0d words, expected 6", obs_dout.size());
        end
        for (int i = 0; i < 6 && i < obs_dout.size(); i++) begin
            n_vec++;
            if (obs_dout[i] !== exp_dout[i] || obs_ch[i] !== ch_ref[i] || obs_last[i] !== (i == 2)) begin
                n_err++;
                $display("[TB] FAIL last_word%0d: got dout=%0d ch=%0d last=%b, expected dout=%0d ch=%0d last=%b",
                         i, obs_dout[i], obs_ch[i], obs_last[i], exp_dout[i], ch_ref[i], (i == 2));
            end
        end
    endtask

    task automatic test_backpressure();
        set_ready_all();
        for (int i = 3; i < 8; i++) rdy_pat[i] = 1'b0;
        clear_stim();
        for (int i = 0; i < 10; i++) add_word(int'($urandom_range(255)), 1'b0);
        build_expected();
        run_stream(100);
        set_ready_all();
        n_vec++;
        if (obs_dout.size() != 10) begin
            n_err++;
            $display("[TB] FAIL bp_count: got %0d words, expected 10", obs_dout.size());
        end
        for (int i = 0; i < 10 && i < obs_dout.size(); i++) begin
            n_vec++;
            if (obs_dout[i] !== exp_dout[i] || obs_ch[i] !== exp_ch[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("[TB] FAIL bp_word%0d: got dout=%0d ch=%0d, expected dout=%0d ch=%0d",
                         i, obs_dout[i], obs_ch[i], exp_dout[i], exp_ch[i]);
            end
        end
        n_vec++;
        if (rdy_low_cyc.size() != 5 || (rdy_low_cyc.size() > 0 && rdy_low_cyc[0] != 3)) begin
            n_err++;
            $display("[TB] FAIL bp_din_ready: got %0d low cycles first at %0d, expected 5 first at 3",
                     rdy_low_cyc.size(), (rdy_low_cyc.size() > 0) ? rdy_low_cyc[0] : -1);
        end
        n_vec++;
        if (hold_viol != 0) begin
            n_err++;
            $display("[TB] FAIL bp_hold: got %0d unstable held cycles, expected 0", hold_viol);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_drain: got dout_valid=%b after stream, expected 0", bus.dout_valid);
        end
    endtask

    task automatic test_collision();
        int c;
        c = mdl_ch;
        write_bias(c, -7);
        clear_stim();
        add_word(1, 1'b1, 1'b1, c, 20);
        for (int i = 0; i < 4; i++) add_word(1, 1'b0);
        build_expected();
        run_stream(60);
        n_vec++;
        if (obs_dout.size() != 5) begin
            n_err++;
            $display("[TB] FAIL coll_count: got %0d words, expected 5", obs_dout.size());
        end else begin
            n_vec++;
            if (obs_dout[0] !== 1031 + ROUND || obs_dout[1 + c] !== 1004 + ROUND) begin
                n_err++;
                $display("[TB] FAIL coll_bias: got old=%0d new=%0d, expected old=%0d new=%0d",
                         obs_dout[0], obs_dout[1 + c], 1031 + ROUND, 1004 + ROUND);
            end
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (obs_dout[i] !== exp_dout[i] || obs_ch[i] !== exp_ch[i]) begin
                    n_err++;
                    $display("[TB] FAIL coll_word%0d: got dout=%0d ch=%0d, expected dout=%0d ch=%0d",
                             i, obs_dout[i], obs_ch[i], exp_dout[i], exp_ch[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 512; i++) rdy_pat[i] = ($urandom_range(3) != 0);
        clear_stim();
        for (int i = 0; i < 60; i++)
            add_word(int'($urandom_range(255)), ($urandom_range(5) == 0), ($urandom_range(3) == 0),
                     int'($urandom_range(N_CH - 1)), int'($urandom_range(255)) - 128);
        build_expected();
        run_stream(3000);
        set_ready_all();
        n_vec++;
        if (obs_dout.size() != 60) begin
            n_err++;
            $display("[TB] FAIL rand_count: got %0d words, expected 60", obs_dout.size());
        end
        for (int i = 0; i < 60 && i < obs_dout.size(); i++) begin
            n_vec++;
            if (obs_dout[i] !== exp_dout[i] || obs_ch[i] !== exp_ch[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("[TB] FAIL rand_word%0d: got dout=%0d ch=%0d last=%b, expected dout=%0d ch=%0d last=%b",
                         i, obs_dout[i], obs_ch[i], obs_last[i], exp_dout[i], exp_ch[i], exp_last[i]);
            end
        end
        n_vec++;
        if (hold_viol != 0) begin
            n_err++;
            $display("[TB] FAIL rand_hold: got %0d unstable held cycles, expected 0", hold_viol);
        end
    endtask

    task automatic test_reset_midflight();
        write_bias(0, 50);
        @(negedge clk);
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b1;
        bus.din        = q_t'(9);
        bus.din_last   = 1'b0;
        @(negedge clk);
        bus.din = q_t'(10);
        @(negedge clk);
        bus.din_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.dout_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL flight_valid: got dout_valid=%b, expected 1", bus.dout_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || bus.dout !== '0 || bus.dout_ch !== '0) begin
            n_err++;
            $display("[TB] FAIL flight_flush: got valid=%b ready=%b dout=%0d ch=%0d, expected 0 1 0 0",
                     bus.dout_valid, bus.din_ready, bus.dout, bus.dout_ch);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        model_reset();
        clear_stim();
        add_word(7, 1'b0);
        build_expected();
        run_stream(40);
        n_vec++;
        if (obs_dout.size() != 1 || obs_dout[0] !== 7168 + ROUND || obs_ch[0] !== 0) begin
            n_err++;
            $display("[TB] FAIL flight_after: got %0d words dout=%0d ch=%0d, expected 1 word dout=%0d ch=0",
                     obs_dout.size(), (obs_dout.size() > 0) ? obs_dout[0] : -1,
                     (obs_ch.size() > 0) ? obs_ch[0] : -1, 7168 + ROUND);
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        bus.bias_we    = 1'b0;
        bus.bias_addr  = '0;
        bus.bias_wdata = '0;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.din_last   = 1'b0;
        bus.dout_ready = 1'b1;
        set_ready_all();
        model_reset();

        test_reset();
        test_basic();
        test_bias_clamp();
        test_last_wrap();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_midflight();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
